// File: rtl/upc_loop_monitor.sv
// Passive monitor for an HLS-style FSM: counts module transactions, loop runs and iterations, and records latencies.
// Optional initiation-interval measurement is enabled by defining UPC_LOOP_MONITOR_II_EN.
module upc_loop_monitor #(
  parameter int STATE_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic               finish,
  output logic               mod_busy,
  output logic               loop_busy,
  output logic [CNT_W-1:0]   mod_txn_cnt,
  output logic [CNT_W-1:0]   mod_last_lat,
  output logic [CNT_W-1:0]   loop_run_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   loop_last_lat,
  output logic [CNT_W-1:0]   loop_last_trip,
  output logic [CNT_W-1:0]   last_ii,
  output logic [CNT_W-1:0]   min_ii,
  output logic               finished,
  output logic               err
);

  typedef enum logic [1:0] {MOD_IDLE, MOD_BUSY, MOD_WAIT} mod_state_t;
  typedef enum logic {LOOP_IDLE, LOOP_RUN} loop_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  mod_state_t        mod_state_reg, mod_state_next;
  loop_state_t       loop_state_reg, loop_state_next;
  logic [CNT_W-1:0]  mod_cyc_reg, mod_cyc_next;
  logic [CNT_W-1:0]  mod_txn_reg, mod_txn_next;
  logic [CNT_W-1:0]  mod_lat_reg, mod_lat_next;
  logic [CNT_W-1:0]  loop_cyc_reg, loop_cyc_next;
  logic [CNT_W-1:0]  run_e_reg, run_e_next;
  logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;
  logic [CNT_W-1:0]  loop_lat_reg, loop_lat_next;
  logic [CNT_W-1:0]  trip_reg, trip_next;
  logic [CNT_W-1:0]  is_reg, is_next;
  logic [CNT_W-1:0]  ie_reg, ie_next;
  logic              err_reg, err_next;
  logic              finished_reg, finished_next;

  logic ev_s, ev_e, ev_q, loop_exit;

  assign ev_s = (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
  assign ev_e = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
  assign ev_q = (cur_state == quit_state) & ~quit_block & quit_enable & (ev_e | ~quit_at_end);
  // A quit behaves exactly like loop_done, so it still needs loop_continue to leave RUN.
  assign loop_exit = (loop_state_reg == LOOP_RUN) & (loop_done | ev_q) & loop_continue;

  // The ready handshakes carry no information the counters need.
  logic unused_ready;
  assign unused_ready = loop_ready ^ ap_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mod_state_reg  <= MOD_IDLE;
      loop_state_reg <= LOOP_IDLE;
      mod_cyc_reg    <= '0;
      mod_txn_reg    <= '0;
      mod_lat_reg    <= '0;
      loop_cyc_reg   <= '0;
      run_e_reg      <= '0;
      run_cnt_reg    <= '0;
      loop_lat_reg   <= '0;
      trip_reg       <= '0;
      is_reg         <= '0;
      ie_reg         <= '0;
      err_reg        <= 1'b0;
      finished_reg   <= 1'b0;
    end else begin
      mod_state_reg  <= mod_state_next;
      loop_state_reg <= loop_state_next;
      mod_cyc_reg    <= mod_cyc_next;
      mod_txn_reg    <= mod_txn_next;
      mod_lat_reg    <= mod_lat_next;
      loop_cyc_reg   <= loop_cyc_next;
      run_e_reg      <= run_e_next;
      run_cnt_reg    <= run_cnt_next;
      loop_lat_reg   <= loop_lat_next;
      trip_reg       <= trip_next;
      is_reg         <= is_next;
      ie_reg         <= ie_next;
      err_reg        <= err_next;
      finished_reg   <= finished_next;
    end
  end

  always_comb begin
    mod_state_next  = mod_state_reg;
    loop_state_next = loop_state_reg;
    mod_cyc_next    = mod_cyc_reg;
    mod_txn_next    = mod_txn_reg;
    mod_lat_next    = mod_lat_reg;
    loop_cyc_next   = loop_cyc_reg;
    run_e_next      = run_e_reg;
    run_cnt_next    = run_cnt_reg;
    loop_lat_next   = loop_lat_reg;
    trip_next       = trip_reg;
    is_next         = is_reg;
    ie_next         = ie_reg;
    err_next        = err_reg;
    finished_next   = finished_reg;
    // Once finished is registered, everything holds until reset.
    if (!finished_reg) begin
      finished_next = finish;
      case (mod_state_reg)
        MOD_IDLE: begin
          if (ap_start) begin
            mod_state_next = MOD_BUSY;
            mod_cyc_next   = CNT_ONE;
          end
        end
        MOD_BUSY: begin
          if (ap_done) begin
            mod_lat_next   = sat_inc(mod_cyc_reg);
            mod_txn_next   = sat_inc(mod_txn_reg);
            mod_state_next = ap_continue ? MOD_IDLE : MOD_WAIT;
          end else begin
            mod_cyc_next = sat_inc(mod_cyc_reg);
          end
        end
        MOD_WAIT: begin
          if (ap_continue) mod_state_next = MOD_IDLE;
        end
        default: mod_state_next = MOD_IDLE;
      endcase

      if (ev_s) is_next = sat_inc(is_reg);
      if (ev_e) ie_next = sat_inc(ie_reg);

      case (loop_state_reg)
        LOOP_IDLE: begin
          if (loop_start) begin
            loop_state_next = LOOP_RUN;
            loop_cyc_next   = CNT_ONE;
            run_e_next      = '0;
          end
        end
        default: begin
          if (loop_exit) begin
            loop_lat_next = sat_inc(loop_cyc_reg);
            trip_next     = ev_e ? sat_inc(run_e_reg) : run_e_reg;
            run_cnt_next  = sat_inc(run_cnt_reg);
            // A back-to-back loop_start begins a fresh run on the exit cycle.
            loop_state_next = loop_start ? LOOP_RUN : LOOP_IDLE;
            loop_cyc_next   = CNT_ONE;
            run_e_next      = '0;
          end else begin
            loop_cyc_next = sat_inc(loop_cyc_reg);
            if (ev_e) run_e_next = sat_inc(run_e_reg);
          end
        end
      endcase

      err_next = err_reg
               | ((ev_s | ev_e) & (loop_state_reg == LOOP_IDLE))
               | (ap_done & (mod_state_reg == MOD_IDLE))
               | (ie_next > is_next);
    end
  end

  assign mod_busy       = (mod_state_reg != MOD_IDLE);
  assign loop_busy      = (loop_state_reg == LOOP_RUN);
  assign mod_txn_cnt    = mod_txn_reg;
  assign mod_last_lat   = mod_lat_reg;
  assign loop_run_cnt   = run_cnt_reg;
  assign iter_start_cnt = is_reg;
  assign iter_end_cnt   = ie_reg;
  assign loop_last_lat  = loop_lat_reg;
  assign loop_last_trip = trip_reg;
  assign finished       = finished_reg;
  assign err            = err_reg;

`ifdef UPC_LOOP_MONITOR_II_EN
  logic [CNT_W-1:0] ii_cyc_reg, ii_cyc_next;
  logic [CNT_W-1:0] last_ii_reg, last_ii_next;
  logic [CNT_W-1:0] min_ii_reg, min_ii_next;
  logic             have_s_reg, have_s_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ii_cyc_reg  <= '0;
      last_ii_reg <= '0;
      min_ii_reg  <= '1;
      have_s_reg  <= 1'b0;
    end else begin
      ii_cyc_reg  <= ii_cyc_next;
      last_ii_reg <= last_ii_next;
      min_ii_reg  <= min_ii_next;
      have_s_reg  <= have_s_next;
    end
  end

  // ii_cyc_reg holds the distance from the previous in-run S to the current cycle.
  always_comb begin
    ii_cyc_next  = ii_cyc_reg;
    last_ii_next = last_ii_reg;
    min_ii_next  = min_ii_reg;
    have_s_next  = have_s_reg;
    if (!finished_reg) begin
      ii_cyc_next = sat_inc(ii_cyc_reg);
      if ((loop_state_reg == LOOP_RUN) && ev_s) begin
        ii_cyc_next = CNT_ONE;
        have_s_next = 1'b1;
        if (have_s_reg) begin
          last_ii_next = ii_cyc_reg;
          if (ii_cyc_reg < min_ii_reg) min_ii_next = ii_cyc_reg;
        end
      end
      if (loop_exit) have_s_next = 1'b0;
    end
  end

  assign last_ii = last_ii_reg;
  assign min_ii  = min_ii_reg;
`else
  assign last_ii = '0;
  assign min_ii  = '1;
`endif

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Self-checking bench for upc_loop_monitor: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timestamp-based behavioural model.
module tb_upc_loop_monitor;
  localparam int SW   = 3;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [SW-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
  logic ap_start, ap_ready, ap_done, ap_continue, finish;
  logic mod_busy, loop_busy, finished, err;
  logic [CW-1:0] mod_txn_cnt, mod_last_lat, loop_run_cnt, iter_start_cnt, iter_end_cnt;
  logic [CW-1:0] loop_last_lat, loop_last_trip, last_ii, min_ii;

  always #5 clock = ~clock;

  upc_loop_monitor #(.STATE_W(SW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .finish(finish),
    .mod_busy(mod_busy), .loop_busy(loop_busy),
    .mod_txn_cnt(mod_txn_cnt), .mod_last_lat(mod_last_lat),
    .loop_run_cnt(loop_run_cnt), .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .loop_last_lat(loop_last_lat), .loop_last_trip(loop_last_trip),
    .last_ii(last_ii), .min_ii(min_ii), .finished(finished), .err(err)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_on   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: remembers start timestamps and event tallies, derives outputs arithmetically.
  bit m_busy = 0, m_wait = 0, m_run = 0, m_have_s = 0, m_err = 0, m_fin = 0;
  int m_mstart = 0, m_txn = 0, m_mlat = 0;
  int m_rstart = 0, m_re = 0, m_runs = 0, m_llat = 0, m_trip = 0;
  int m_is = 0, m_ie = 0, m_last_s = 0, m_last_ii = 0, m_min_ii = CMAX;
  int tcyc = 0;
  bit s, e, q, mod_idle, was_run;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_wait = 0; m_run = 0; m_have_s = 0; m_err = 0; m_fin = 0;
      m_txn = 0; m_mlat = 0; m_re = 0; m_runs = 0; m_llat = 0; m_trip = 0;
      m_is = 0; m_ie = 0; m_last_ii = 0; m_min_ii = CMAX;
    end else begin
      if (!m_fin) begin
        s = (cur_state == iter_start_state) && !iter_start_block && iter_start_enable;
        e = (cur_state == iter_end_state) && !iter_end_block && iter_end_enable;
        q = (cur_state == quit_state) && !quit_block && quit_enable && (e || !quit_at_end);
        mod_idle = !m_busy && !m_wait;
        was_run  = m_run;
        if (mod_idle) begin
          if (ap_start) begin m_busy = 1; m_mstart = tcyc; end
        end else if (m_busy) begin
          if (ap_done) begin
            m_mlat = sat(tcyc - m_mstart + 1);
            m_txn  = sat(m_txn + 1);
            m_busy = 0;
            m_wait = !ap_continue;
          end
        end else if (ap_continue) m_wait = 0;
        if (s) m_is = sat(m_is + 1);
        if (e) m_ie = sat(m_ie + 1);
        if (!was_run) begin
          if (loop_start) begin m_run = 1; m_rstart = tcyc; m_re = 0; m_have_s = 0; end
        end else begin
          if (e) m_re++;
          if (s) begin
            if (m_have_s) begin
              m_last_ii = sat(tcyc - m_last_s);
              if (m_last_ii < m_min_ii) m_min_ii = m_last_ii;
            end
            m_have_s = 1;
            m_last_s = tcyc;
          end
          if ((loop_done || q) && loop_continue) begin
            m_llat = sat(tcyc - m_rstart + 1);
            m_trip = sat(m_re);
            m_runs = sat(m_runs + 1);
            if (loop_start) begin m_rstart = tcyc; m_re = 0; m_have_s = 0; end
            else m_run = 0;
          end
        end
        if ((s || e) && !was_run) m_err = 1;
        if (ap_done && mod_idle) m_err = 1;
        if (m_ie > m_is) m_err = 1;
        if (finish) m_fin = 1;
      end
      tcyc++;
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("mod_busy", mod_busy, m_busy || m_wait);
      chk("loop_busy", loop_busy, m_run);
      chk("mod_txn_cnt", mod_txn_cnt, m_txn);
      chk("mod_last_lat", mod_last_lat, m_mlat);
      chk("loop_run_cnt", loop_run_cnt, m_runs);
      chk("iter_start_cnt", iter_start_cnt, m_is);
      chk("iter_end_cnt", iter_end_cnt, m_ie);
      chk("loop_last_lat", loop_last_lat, m_llat);
      chk("loop_last_trip", loop_last_trip, m_trip);
`ifdef UPC_LOOP_MONITOR_II_EN
      chk("last_ii", last_ii, m_last_ii);
      chk("min_ii", min_ii, m_min_ii);
`else
      chk("last_ii", last_ii, 0);
      chk("min_ii", min_ii, CMAX);
`endif
      chk("finished", finished, m_fin);
      chk("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    cur_state = 0; iter_start_state = 1; iter_end_state = 2; quit_state = 3;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 1; iter_end_enable = 1; quit_enable = 1;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic end_loop();
    loop_done = 1; loop_continue = 1;
    tick();
    loop_done = 0; loop_continue = 0;
  endtask

  initial begin
    clr_inputs();
    tick();
    tick();
    chk_on = 1;
    chk("reset_min_ii", min_ii, CMAX);
    chk("reset_txn", mod_txn_cnt, 0);
    reset = 1;

    // Module transaction: start at cycle 0, done at cycle 9.
    ap_start = 1; tick(); ap_start = 0;
    repeat (8) tick();
    chk("mod_busy_pre_done", mod_busy, 1);
    ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    chk("r17_lat", mod_last_lat, 10);
    chk("r17_txn", mod_txn_cnt, 1);
    chk("r17_busy", mod_busy, 0);

    // Loop run with 4 iterations, S every 3 cycles and E one cycle later.
    do_reset();
    loop_start = 1; tick(); loop_start = 0;
    for (int k = 0; k < 4; k++) begin
      cur_state = 1; tick();
      cur_state = 2; tick();
      cur_state = 0; tick();
    end
    end_loop();
    chk("r18_is", iter_start_cnt, 4);
    chk("r18_ie", iter_end_cnt, 4);
    chk("r18_trip", loop_last_trip, 4);
    chk("r18_runs", loop_run_cnt, 1);
    chk("r18_lat", loop_last_lat, 14);
    chk("r18_err", err, 0);
`ifdef UPC_LOOP_MONITOR_II_EN
    chk("r18_last_ii", last_ii, 3);
    chk("r18_min_ii", min_ii, 3);
`else
    chk("r18_last_ii", last_ii, 0);
    chk("r18_min_ii", min_ii, CMAX);
`endif

    // Qualified-out starts, then a start while the loop is idle.
    do_reset();
    loop_start = 1; tick(); loop_start = 0;
    cur_state = 1; iter_start_block = 1; tick();
    iter_start_block = 0; iter_start_enable = 0; tick();
    iter_start_enable = 1; cur_state = 0;
    chk("r19_is_blocked", iter_start_cnt, 0);
    chk("r19_err_clean", err, 0);
    end_loop();
    cur_state = 1; tick(); cur_state = 0;
    chk("r19_err_idle_s", err, 1);
    chk("r19_is_idle", iter_start_cnt, 1);

    // ap_done held back by ap_continue.
    do_reset();
    ap_start = 1; tick(); ap_start = 0;
    tick();
    ap_done = 1; tick(); ap_done = 0;
    for (int k = 0; k < 3; k++) begin
      chk("r20_busy_wait", mod_busy, 1);
      tick();
    end
    chk("r20_txn_early", mod_txn_cnt, 1);
    ap_continue = 1; tick(); ap_continue = 0;
    chk("r20_busy_end", mod_busy, 0);
    chk("r20_lat", mod_last_lat, 3);

    // finish mid-run freezes everything from the following cycle.
    do_reset();
    loop_start = 1; tick(); loop_start = 0;
    cur_state = 1; tick();
    finish = 1; tick(); finish = 0;
    repeat (3) tick();
    cur_state = 0;
    end_loop();
    chk("r21_finished", finished, 1);
    chk("r21_is", iter_start_cnt, 2);
    chk("r21_runs", loop_run_cnt, 0);
    chk("r21_loop_busy", loop_busy, 1);

    // Reset in the middle of a run.
    do_reset();
    loop_start = 1; tick(); loop_start = 0;
    cur_state = 1; tick(); cur_state = 0; tick();
    cur_state = 1; tick(); cur_state = 0; tick(); tick();
    chk("r22_is_pre", iter_start_cnt, 2);
    reset = 0;
    #2;
    chk("r22_loop_busy", loop_busy, 0);
    chk("r22_is", iter_start_cnt, 0);
    chk("r22_min_ii", min_ii, CMAX);
    chk("r22_last_lat", loop_last_lat, 0);
    tick();
    reset = 1;
    loop_start = 1; tick(); loop_start = 0;
    repeat (3) tick();
    end_loop();
    chk("r22_new_lat", loop_last_lat, 5);
    chk("r22_new_runs", loop_run_cnt, 1);

    // Randomized segments; segment 2 drives every counter into saturation.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        if (seg == 2) begin
          clr_inputs();
          iter_end_state = 1;
          quit_enable = 0;
          loop_start = (i == 0);
          ap_start = (i == 0);
          cur_state = (i == 0) ? 3'd0 : 3'd1;
          if (i == 399) begin loop_done = 1; loop_continue = 1; end
        end else begin
          cur_state = 3'($urandom_range(0, 3));
          iter_start_state = 3'($urandom_range(0, 3));
          iter_end_state = 3'($urandom_range(0, 3));
          quit_state = 3'($urandom_range(0, 3));
          iter_start_block = ($urandom_range(0, 3) == 0);
          iter_end_block = ($urandom_range(0, 3) == 0);
          quit_block = ($urandom_range(0, 3) == 0);
          iter_start_enable = ($urandom_range(0, 3) != 0);
          iter_end_enable = ($urandom_range(0, 3) != 0);
          quit_enable = ($urandom_range(0, 3) == 0);
          quit_at_end = 1'($urandom_range(0, 1));
          loop_start = ($urandom_range(0, 7) == 0);
          loop_done = ($urandom_range(0, 5) == 0);
          loop_continue = ($urandom_range(0, 3) != 0);
          loop_ready = 1'($urandom_range(0, 1));
          ap_start = ($urandom_range(0, 5) == 0);
          ap_done = ($urandom_range(0, 5) == 0);
          ap_continue = 1'($urandom_range(0, 1));
          ap_ready = 1'($urandom_range(0, 1));
          finish = (seg == 4 && i == 200);
        end
        if (seg == 5 && i == 150) reset = 0;
        if (seg == 5 && i == 152) reset = 1;
        tick();
      end
      if (seg == 2) begin
        chk("sat_is", iter_start_cnt, CMAX);
        chk("sat_ie", iter_end_cnt, CMAX);
        chk("sat_loop_lat", loop_last_lat, CMAX);
        chk("sat_trip", loop_last_trip, CMAX);
      end
    end

    clr_inputs();
    tick();
    chk_on = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
